// File: rtl/mac_pkg.sv
// Shared widths, mode encoding and saturation limits
// for the pipelined multiply-accumulate unit.
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 39;
    localparam int SAT_W      = 128;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Limits are built at SAT_W bits; callers size-cast to their width.
    function automatic logic [SAT_W-1:0] sat_max(input logic mode, input int w);
        logic [SAT_W-1:0] one;
        one = SAT_W'(1);
        if (mode == MODE_SIGNED)
            sat_max = (one << (w - 1)) - one;
        else
            sat_max = (one << w) - one;
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input logic mode, input int w);
        logic [SAT_W-1:0] one;
        one = SAT_W'(1);
        if (mode == MODE_SIGNED)
            sat_min = one << (w - 1);
        else
            sat_min = '0;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Stage 1: operand multiply with mode-dependent extension,
// registered together with the sample's control bits.
module mac_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                R_n,
    input  logic                valid_i,
    input  logic                last_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [DATA_W-1:0]   x_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                valid_o,
    output logic                last_o,
    output logic                start_o,
    output logic                mode_o,
    output logic [2*DATA_W-1:0] prod_o
);

    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                start_q, start_d;
    logic                mode_q, mode_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [2*DATA_W-1:0] x_ext, b_ext;

    // Extending both operands then truncating the product gives
    // the exact signed or unsigned 2*DATA_W-bit result.
    always_comb begin
        x_ext   = {{DATA_W{mode_i & x_i[DATA_W-1]}}, x_i};
        b_ext   = {{DATA_W{mode_i & b_i[DATA_W-1]}}, b_i};
        valid_d = valid_i;
        last_d  = last_q;
        start_d = start_q;
        mode_d  = mode_q;
        prod_d  = prod_q;
        if (valid_i) begin
            last_d  = last_i;
            start_d = start_i;
            mode_d  = mode_i;
            prod_d  = x_ext * b_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!R_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            mode_q  <= MODE_UNSIGNED;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            prod_q  <= prod_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign start_o = start_q;
    assign mode_o  = mode_q;
    assign prod_o  = prod_q;

endmodule

// File: rtl/pipelined_mac.sv
// Two-stage multiply-accumulate with per-frame mode capture,
// saturating accumulation and sticky overflow.
module pipelined_mac
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] B,
    output logic [ACC_W-1:0]  y,
    output logic              y_valid,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;

    logic             start_q, start_d;
    logic             fmode_q, fmode_d;
    logic             mode_eff;
    logic             s1_valid, s1_last, s1_start, s1_mode;
    logic [PW-1:0]    s1_prod;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             y_valid_q, y_valid_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] base, p_ext, sat_hi, sat_lo;
    logic [ACC_W:0]   sum_x;
    logic             ovf_now;

    // Input-side frame tracking: the first sample fixes the mode.
    always_comb begin
        start_d  = start_q;
        fmode_d  = fmode_q;
        mode_eff = start_q ? signed_mode : fmode_q;
        if (valid_in) begin
            start_d = last_in;
            fmode_d = mode_eff;
        end
    end

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk     (clk),
        .R_n     (R_n),
        .valid_i (valid_in),
        .last_i  (last_in),
        .start_i (start_q),
        .mode_i  (mode_eff),
        .x_i     (X),
        .b_i     (B),
        .valid_o (s1_valid),
        .last_o  (s1_last),
        .start_o (s1_start),
        .mode_o  (s1_mode),
        .prod_o  (s1_prod)
    );

    always_comb begin
        base   = s1_start ? '0 : acc_q;
        p_ext  = {{(ACC_W-PW){s1_mode & s1_prod[PW-1]}}, s1_prod};
        sum_x  = {s1_mode & base[ACC_W-1], base}
               + {s1_mode & p_ext[ACC_W-1], p_ext};
        sat_hi = ACC_W'(sat_max(s1_mode, ACC_W));
        sat_lo = ACC_W'(sat_min(s1_mode, ACC_W));
        if (s1_mode == MODE_SIGNED)
            ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];
        else
            ovf_now = sum_x[ACC_W];
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        y_valid_d = 1'b0;
        if (s1_valid) begin
            // In signed mode the extra top bit is the true sign.
            if (!ovf_now)
                acc_d = sum_x[ACC_W-1:0];
            else if (s1_mode == MODE_SIGNED && sum_x[ACC_W])
                acc_d = sat_lo;
            else
                acc_d = sat_hi;
            ovf_d     = ovf_now | (ovf_q & ~s1_start);
            y_valid_d = s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!R_n) begin
            start_q   <= 1'b1;
            fmode_q   <= MODE_UNSIGNED;
            acc_q     <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            start_q   <= start_d;
            fmode_q   <= fmode_d;
            acc_q     <= acc_d;
            y_valid_q <= y_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign y       = acc_q;
    assign y_valid = y_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pipelined_mac.sv
// Directed bench for pipelined_mac: default 39-bit instance
// plus a 33-bit instance sharing the same stimulus.
module tb_pipelined_mac;

    logic        clk = 1'b0;
    logic        R_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        last_in = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] X = '0;
    logic [15:0] B = '0;

    logic [38:0] y39;
    logic        yv39, ovf39;
    logic [32:0] y33;
    logic        yv33, ovf33;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipelined_mac #(.DATA_W(16), .ACC_W(39)) dut39 (
        .clk         (clk),
        .R_n         (R_n),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .signed_mode (signed_mode),
        .X           (X),
        .B           (B),
        .y           (y39),
        .y_valid     (yv39),
        .ovf         (ovf39)
    );

    pipelined_mac #(.DATA_W(16), .ACC_W(33)) dut33 (
        .clk         (clk),
        .R_n         (R_n),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .signed_mode (signed_mode),
        .X           (X),
        .B           (B),
        .y           (y33),
        .y_valid     (yv33),
        .ovf         (ovf33)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic v, input logic l, input logic m,
                        input logic [15:0] x, input logic [15:0] b);
        valid_in    = v;
        last_in     = l;
        signed_mode = m;
        X           = x;
        B           = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        // reset state
        idle();
        idle();
        check("rst_y", 64'(y39), 64'd0);
        check("rst_yv", 64'(yv39), 64'd0);
        check("rst_ovf", 64'(ovf39), 64'd0);
        check("rst_y33", 64'(y33), 64'd0);

        // unsigned frame, first sample on the release edge
        R_n = 1'b1;
        send(1, 0, 0, 16'd2, 16'd3);
        send(1, 0, 0, 16'd5, 16'd4);
        check("u_y1", 64'(y39), 64'd6);
        check("u_yv1", 64'(yv39), 64'd0);
        send(1, 0, 0, 16'd1, 16'd1);
        check("u_y2", 64'(y39), 64'd26);
        send(1, 1, 0, 16'd16, 16'd3);
        check("u_y3", 64'(y39), 64'd27);
        idle();
        check("u_y4", 64'(y39), 64'd75);
        check("u_yv4", 64'(yv39), 64'd1);
        check("u_ovf4", 64'(ovf39), 64'd0);
        idle();
        check("u_yv_end", 64'(yv39), 64'd0);
        check("u_hold", 64'(y39), 64'd75);

        // signed single-sample frame: -3 * 7
        send(1, 1, 1, 16'hFFFD, 16'd7);
        idle();
        check("s1_y", 64'(y39), 64'h7F_FFFF_FFEB);
        check("s1_yv", 64'(yv39), 64'd1);
        idle();
        check("s1_yv_end", 64'(yv39), 64'd0);

        // back-to-back single-sample frames
        send(1, 1, 0, 16'd1, 16'd1);
        send(1, 1, 0, 16'd2, 16'd2);
        check("b2b_y1", 64'(y39), 64'd1);
        check("b2b_yv1", 64'(yv39), 64'd1);
        idle();
        check("b2b_y2", 64'(y39), 64'd4);
        check("b2b_yv2", 64'(yv39), 64'd1);
        idle();
        check("b2b_yv3", 64'(yv39), 64'd0);

        // mode taken from the first sample only
        send(1, 0, 0, 16'hFFFF, 16'd1);
        send(1, 1, 1, 16'hFFFF, 16'd1);
        idle();
        check("mode_u", 64'(y39), 64'd131070);
        send(1, 0, 1, 16'hFFFF, 16'd1);
        send(1, 1, 0, 16'hFFFF, 16'd1);
        idle();
        check("mode_s", 64'(y39), 64'h7F_FFFF_FFFE);

        // three 0x7FFF^2 samples fit in 33 signed bits
        send(1, 0, 1, 16'h7FFF, 16'h7FFF);
        send(1, 0, 1, 16'h7FFF, 16'h7FFF);
        send(1, 1, 1, 16'h7FFF, 16'h7FFF);
        idle();
        check("fit_y33", 64'(y33), 64'd3221028867);
        check("fit_ovf33", 64'(ovf33), 64'd0);
        check("fit_y39", 64'(y39), 64'd3221028867);

        // four (+2^30) products exceed the 33-bit signed max
        send(1, 0, 1, 16'h8000, 16'h8000);
        send(1, 0, 1, 16'h8000, 16'h8000);
        send(1, 0, 1, 16'h8000, 16'h8000);
        send(1, 1, 1, 16'h8000, 16'h8000);
        check("pos_y33_3", 64'(y33), 64'hC000_0000);
        idle();
        check("pos_sat33", 64'(y33), 64'hFFFF_FFFF);
        check("pos_ovf33", 64'(ovf33), 64'd1);
        check("pos_yv33", 64'(yv33), 64'd1);
        check("pos_y39", 64'(y39), 64'h1_0000_0000);
        check("pos_ovf39", 64'(ovf39), 64'd0);
        send(1, 1, 0, 16'd1, 16'd1);
        check("ovf_held", 64'(ovf33), 64'd1);
        idle();
        check("ovf_clr", 64'(ovf33), 64'd0);
        check("ovf_clr_y", 64'(y33), 64'd1);

        // unsigned saturation to all-ones
        send(1, 0, 0, 16'hFFFF, 16'hFFFF);
        send(1, 0, 0, 16'hFFFF, 16'hFFFF);
        send(1, 1, 0, 16'hFFFF, 16'hFFFF);
        idle();
        check("u_sat33", 64'(y33), 64'h1_FFFF_FFFF);
        check("u_ovf33", 64'(ovf33), 64'd1);
        check("u_y39", 64'(y39), 64'h2_FFFA_0003);

        // negative saturation to the 33-bit signed min
        for (int i = 0; i < 5; i++)
            send(1, (i == 4), 1, 16'h8000, 16'h7FFF);
        idle();
        check("neg_sat33", 64'(y33), 64'h1_0000_0000);
        check("neg_ovf33", 64'(ovf33), 64'd1);

        // reset mid-frame discards the partial sum
        send(1, 0, 0, 16'd1, 16'd2);
        send(1, 0, 0, 16'd3, 16'd4);
        R_n = 1'b0;
        idle();
        check("abort_y", 64'(y39), 64'd0);
        check("abort_yv", 64'(yv39), 64'd0);
        check("abort_ovf33", 64'(ovf33), 64'd0);
        idle();
        check("abort_yv2", 64'(yv39), 64'd0);
        R_n = 1'b1;
        send(1, 0, 0, 16'd1, 16'd1);
        check("re_yv0", 64'(yv39), 64'd0);
        send(1, 0, 0, 16'd2, 16'd2);
        check("re_y1", 64'(y39), 64'd1);
        send(1, 0, 0, 16'd3, 16'd3);
        check("re_y2", 64'(y39), 64'd5);
        send(1, 1, 0, 16'd4, 16'd4);
        check("re_y3", 64'(y39), 64'd14);
        idle();
        check("re_y4", 64'(y39), 64'd30);
        check("re_yv4", 64'(yv39), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
